// File: rtl/issue_pkg.sv
// Shared types for the multi-issue wakeup/select window: entry layout, default widths and unit classes.
// Entry widths follow the IQ_* localparams; the top-level defaults are taken from here.
package issue_pkg;
  localparam int IQ_DEPTH    = 16;
  localparam int IQ_UNITS    = 3;
  localparam int IQ_WB_PORTS = 2;
  localparam int IQ_TAG      = 6;
  localparam int IQ_PAYLOAD  = 40;
  localparam int IQ_UW       = $clog2(IQ_UNITS);

  typedef enum logic [IQ_UW-1:0] {
    EXE_ALU = IQ_UW'(0),
    EXE_MUL = IQ_UW'(1),
    EXE_LSU = IQ_UW'(2)
  } ExeUnit_t;

  typedef struct packed {
    logic                  valid;
    logic [IQ_UW-1:0]      unit;
    logic [IQ_TAG-1:0]     rd;
    logic [IQ_TAG-1:0]     rs1;
    logic                  rs1_rdy;
    logic [IQ_TAG-1:0]     rs2;
    logic                  rs2_rdy;
    logic [IQ_PAYLOAD-1:0] payload;
  } IqEntry_t;
endpackage

// File: rtl/age_matrix.sv
// DEPTH x DEPTH age matrix shared by all issue ports; grant is combinational from registered age.
// Row [i] bit [j] = 1 means entry i is older than entry j; no backpressure of its own.
module age_matrix #(
  parameter int DEPTH = 16,
  parameter int UNITS = 3
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0]             alloc,
  input  logic [DEPTH-1:0]             free,
  input  logic [UNITS-1:0][DEPTH-1:0]  req,
  output logic [UNITS-1:0][DEPTH-1:0]  gnt
);
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (free[i] || alloc[i]) begin
        age_d[i] = '0;
      end else if (valid[i]) begin
        // every surviving entry becomes older than the newcomer
        age_d[i] = age_q[i] | alloc;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int u = 0; u < UNITS; u++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic older_req;
        older_req = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
          older_req = older_req | (req[u][j] & age_q[j][i]);
        end
        gnt[u][i] = req[u][i] & ~older_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
endmodule

// File: rtl/issue_queue_mw.sv
// Wakeup/select window: one enqueue per cycle, up to UNITS oldest-ready issues; enqueue->issue and wakeup->issue >= 1 cycle.
// busy (count==DEPTH, registered) stalls upstream; exe_busy[u] holds back unit u; flush_ empties the window.
module issue_queue_mw
  import issue_pkg::*;
#(
  parameter int DEPTH    = IQ_DEPTH,
  parameter int UNITS    = IQ_UNITS,
  parameter int WB_PORTS = IQ_WB_PORTS,
  parameter int TAG      = IQ_TAG,
  parameter int PAYLOAD  = IQ_PAYLOAD,
  parameter int UW       = $clog2(UNITS)
) (
  input  logic                        clk,
  input  logic                        reset_,
  input  logic                        flush_,
  input  logic                        dec_e_,
  input  logic [UW-1:0]               dec_unit,
  input  logic [TAG-1:0]              dec_rd,
  input  logic [TAG-1:0]              dec_rs1,
  input  logic                        dec_rs1_ready,
  input  logic [TAG-1:0]              dec_rs2,
  input  logic                        dec_rs2_ready,
  input  logic [PAYLOAD-1:0]          dec_payload,
  input  logic [UNITS-1:0]            exe_busy,
  input  logic [WB_PORTS-1:0]         wb_e_,
  input  logic [WB_PORTS*TAG-1:0]     wb_rd,
  output logic [UNITS-1:0]            issue_e_,
  output logic [UNITS*TAG-1:0]        issue_rd,
  output logic [UNITS*TAG-1:0]        issue_rs1,
  output logic [UNITS*TAG-1:0]        issue_rs2,
  output logic [UNITS*PAYLOAD-1:0]    issue_payload,
  output logic                        busy,
  output logic [$clog2(DEPTH):0]      count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  IqEntry_t [DEPTH-1:0]        ent_q, ent_d;
  logic [CW-1:0]               count_q, count_d;
  logic [DEPTH-1:0]            valid_vec, alloc, free_vec;
  logic [UNITS-1:0][DEPTH-1:0] req, gnt;
  logic [UNITS-1:0]            issued;
  logic [IW-1:0]               free_idx;
  logic                        enq;

  function automatic logic [IW-1:0] lowest_free(input logic [DEPTH-1:0] v);
    lowest_free = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!v[i]) lowest_free = IW'(i);
    end
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [UNITS-1:0] v);
    popcnt = '0;
    for (int i = 0; i < UNITS; i++) popcnt = popcnt + CW'(v[i]);
  endfunction

  function automatic logic wb_hit(input logic [TAG-1:0] tag,
                                  input logic [WB_PORTS-1:0] vld_n,
                                  input logic [WB_PORTS*TAG-1:0] tags);
    wb_hit = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (!vld_n[p] && tags[p*TAG +: TAG] == tag) wb_hit = 1'b1;
    end
  endfunction

  assign busy     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign enq      = !dec_e_ && !busy && flush_;
  assign free_idx = lowest_free(valid_vec);

  always_comb begin
    alloc = '0;
    if (enq) alloc[free_idx] = 1'b1;
    for (int i = 0; i < DEPTH; i++) valid_vec[i] = ent_q[i].valid;
  end

  // Requests are masked during flush so no grant can leave in that cycle.
  always_comb begin
    req = '0;
    for (int u = 0; u < UNITS; u++) begin
      for (int i = 0; i < DEPTH; i++) begin
        req[u][i] = flush_ && !exe_busy[u] && ent_q[i].valid && ent_q[i].rs1_rdy &&
                    ent_q[i].rs2_rdy && (ent_q[i].unit == UW'(u));
      end
    end
  end

  age_matrix #(.DEPTH(DEPTH), .UNITS(UNITS)) u_age (
    .clk    (clk),
    .reset_ (reset_),
    .valid  (valid_vec),
    .alloc  (alloc),
    .free   (free_vec),
    .req    (req),
    .gnt    (gnt)
  );

  always_comb begin
    free_vec      = '0;
    issued        = '0;
    issue_e_      = '1;
    issue_rd      = '0;
    issue_rs1     = '0;
    issue_rs2     = '0;
    issue_payload = '0;
    for (int u = 0; u < UNITS; u++) begin
      issued[u]   = |gnt[u];
      issue_e_[u] = ~(|gnt[u]);
      free_vec    = free_vec | gnt[u];
      for (int i = 0; i < DEPTH; i++) begin
        if (gnt[u][i]) begin
          issue_rd[u*TAG +: TAG]              = ent_q[i].rd;
          issue_rs1[u*TAG +: TAG]             = ent_q[i].rs1;
          issue_rs2[u*TAG +: TAG]             = ent_q[i].rs2;
          issue_payload[u*PAYLOAD +: PAYLOAD] = ent_q[i].payload;
        end
      end
    end
  end

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_hit(ent_q[i].rs1, wb_e_, wb_rd)) ent_d[i].rs1_rdy = 1'b1;
      if (wb_hit(ent_q[i].rs2, wb_e_, wb_rd)) ent_d[i].rs2_rdy = 1'b1;
      if (free_vec[i]) ent_d[i].valid = 1'b0;
    end
    if (enq) begin
      ent_d[free_idx] = '{valid:   1'b1,
                          unit:    dec_unit,
                          rd:      dec_rd,
                          rs1:     dec_rs1,
                          rs1_rdy: dec_rs1_ready | wb_hit(dec_rs1, wb_e_, wb_rd),
                          rs2:     dec_rs2,
                          rs2_rdy: dec_rs2_ready | wb_hit(dec_rs2, wb_e_, wb_rd),
                          payload: dec_payload};
    end
    if (!flush_) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q + CW'(enq) - popcnt(issued);
    if (!flush_) count_d = '0;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  enq_while_busy: assert property (@(posedge clk) disable iff (!reset_) !(busy && !dec_e_));
endmodule
